zero_remap_d2: RTL
==================

// Module: zero_remap_d2
// PURPOSE
//  Consumer side of the 2nd-order (3-share) Kronecker-delta zero test in the multiplicative-masking AES S-box.
//  Aligns each Boolean-shared byte with its shared delta bit and applies the zero-to-one map (x ^ delta) before
//  Boolean-to-multiplicative conversion. Holds every delta in a FIFO until the inverted byte returns, then
//  applies the same XOR to undo the mapping. Works strictly share-wise: shares are never combined.
// PARAMETERS
//  LAT    3  cycles from in_data acceptance to a valid kd_delta from the zero-test unit (one per AND level)
//  DEPTH  4  delta FIFO entries; total of in-flight and stored bytes never exceeds DEPTH (DEPTH >= 2)
// PORTS
//  clk             in   1   single clock, all state updates on the rising edge
//  rst             in   1   synchronous reset, active high
//  in_valid        in   1   byte offered for mapping
//  in_ready        out  1   byte can be accepted this cycle
//  in_data         in   24  share0=[7:0], share1=[15:8], share2=[23:16]; also drives the zero-test unit
//  kd_delta        in   3   shared delta from the zero-test unit: [2]=share0, [1]=share1, [0]=share2
//  map_valid       out  1   mapped byte valid, single-cycle pulse, no backpressure
//  map_data        out  24  in_data with delta XORed into bit 0 of each share
//  unmap_in_valid  in   1   inverted byte returning from the inversion datapath
//  unmap_in_ready  out  1   returning byte can be accepted
//  unmap_in_data   in   24  same share layout as in_data
//  unmap_valid     out  1   unmapped byte valid, single-cycle pulse
//  unmap_data      out  24  unmap_in_data with the oldest stored delta XORed into bit 0 of each share
// BEHAVIOUR
//  Reset: all registered outputs are 0. Pipeline valids, FIFO pointers and count are cleared, and in-flight
//   plus stored entries are discarded. Reset wins over any simultaneous handshake.
//  Accept: in_valid & in_ready on edge t loads in_data into stage 1 of a LAT-deep shift register with a valid bit.
//  Alignment: the stage-LAT entry and kd_delta are sampled together on edge t+LAT.
//   After edge t+LAT: map_valid=1 for one cycle.
//   map_data = data ^ {7'b0,d[0], 7'b0,d[1], 7'b0,d[2]} (bits 16, 8, 0). The same edge pushes d into the FIFO.
//   With back-to-back accepts, map_valid stays high on consecutive cycles.
//  Capacity: occ = (valid stages in shift register) + fifo_count. in_ready = (occ < DEPTH), purely from registers.
//   A pop on the same edge does not raise in_ready early.
//  Unmap: unmap_in_ready = (fifo_count != 0). There is no bypass, so a delta pushed on edge e is poppable from e+1.
//   Accept on edge u pops the head. After edge u: unmap_valid=1 for one cycle.
//   unmap_data = unmap_in_data ^ head delta, applied at the same bit positions as map_data.
//  Push and pop on the same edge: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
//  Order is strictly FIFO: the k-th mapped byte's delta unmaps the k-th returning byte.
//  Outputs hold their last data when valid=0. Data is only meaningful when valid=1.
//  Each share uses only its own delta share. No cross-share XOR in any logic (glitch-robust share separation).
//  Values of unmap_in_valid while unmap_in_ready=0 are ignored (no state change, no error flag).
// TESTING
//  1 Reset: assert rst 2 cycles mid-stream -> all valids 0, in_ready=1, unmap_in_ready=0, occ=0 next cycle.
//  2 Zero byte: shares {0x5A,0x3C,0x66} (XOR=0), delta shares {1,0,0} at t+3
//    -> map_data={0x5A,0x3C,0x67} at t+3, fifo_count=1.
//  3 Nonzero: shares {0x01,0x00,0x00}, delta {1,1,0} -> map_data={0x01,0x01,0x01}.
//    Unmap {0xAA,0x55,0x00} -> unmap_data={0xAA,0x54,0x01}.
//  4 Full: 4 back-to-back accepts with no unmap -> in_ready=0 after 4th.
//    5th offer stalls until one unmap pop, then accepted the next cycle.
//  5 Simultaneous: map push and unmap pop on the same edge -> count unchanged, order kept across pointer wrap.
//  6 Empty: unmap_in_valid=1 with empty FIFO -> unmap_in_ready=0, no unmap_valid, state unchanged.

Source files
------------

// File: rtl/zero_remap_d2.sv
`default_nettype none
// ============================================================================
// Module   : zero_remap_d2
// Brief    : Share-wise zero-to-one remap for the 3-share Kronecker-delta test;
//            aligns bytes with their delta, stores deltas until the inverse returns.
// Revision : 1.0
// ============================================================================
module zero_remap_d2 #(
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic [2:0]  kd_delta,
    output logic        map_valid,
    output logic [23:0] map_data,
    input  logic        unmap_in_valid,
    output logic        unmap_in_ready,
    input  logic [23:0] unmap_in_data,
    output logic        unmap_valid,
    output logic [23:0] unmap_data
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);

    logic [23:0]        r_pipe_data [LAT];
    logic [LAT-1:0]     r_pipe_valid;
    logic [2:0]         r_fifo [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_fifo_count;
    logic [c_CNT_W-1:0] r_occ;
    logic               r_map_valid;
    logic [23:0]        r_map_data;
    logic               r_unmap_valid;
    logic [23:0]        r_unmap_data;

    logic        w_accept;
    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_head;
    logic [23:0] w_map_mask;
    logic [23:0] w_unmap_mask;

    assign in_ready       = (r_occ < c_DEPTH);
    assign unmap_in_ready = (r_fifo_count != '0);

    assign w_accept = in_valid & in_ready;
    assign w_pop    = unmap_in_valid & unmap_in_ready;
    assign w_push   = r_pipe_valid[LAT-1];
    assign w_head   = r_fifo[r_rd_ptr];

    // Each delta share only ever touches bit 0 of its own data share
    assign w_map_mask   = {7'b0, kd_delta[0], 7'b0, kd_delta[1], 7'b0, kd_delta[2]};
    assign w_unmap_mask = {7'b0, w_head[0],   7'b0, w_head[1],   7'b0, w_head[2]};

    assign map_valid   = r_map_valid;
    assign map_data    = r_map_data;
    assign unmap_valid = r_unmap_valid;
    assign unmap_data  = r_unmap_data;

    // Payload storage: qualified by valid bits and the FIFO count, so no reset needed
    always_ff @(posedge clk) begin
        r_pipe_data[0] <= in_data;
        for (int i = 1; i < LAT; i++) begin
            r_pipe_data[i] <= r_pipe_data[i-1];
        end
        if (!rst && w_push) begin
            r_fifo[r_wr_ptr] <= kd_delta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_valid  <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fifo_count  <= '0;
            r_occ         <= '0;
            r_map_valid   <= 1'b0;
            r_map_data    <= '0;
            r_unmap_valid <= 1'b0;
            r_unmap_data  <= '0;
        end else begin
            r_pipe_valid[0] <= w_accept;
            for (int i = 1; i < LAT; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
            end

            r_map_valid <= w_push;
            if (w_push) begin
                r_map_data <= r_pipe_data[LAT-1] ^ w_map_mask;
                r_wr_ptr   <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end

            r_unmap_valid <= w_pop;
            if (w_pop) begin
                r_unmap_data <= unmap_in_data ^ w_unmap_mask;
                r_rd_ptr     <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
                2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
                default: r_fifo_count <= r_fifo_count;
            endcase

            // A byte moving from the shift register into the FIFO leaves occupancy unchanged
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire
